// File: rtl/operand_fetch.sv
// operand_fetch: two-stage operand fetch between decode and execute.
//   S1 holds the instruction while the register bank read is in flight,
//   S2 is the registered execute-side output.
// Build option: define OPERAND_FWD_EN to enable EX/MEM and MEM/WB operand
// forwarding with load-use stalls only; without it, any pending write to a
// source register stalls until it has reached the bank.
module operand_fetch #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [4:0]      i_in_rs1,
    input  logic [4:0]      i_in_rs2,
    input  logic [4:0]      i_in_rd,
    input  logic            i_in_reg_write,
    input  logic            i_in_mem_read,
    input  logic [XLEN-1:0] i_in_imm,
    input  logic [3:0]      i_in_alu_op,
    output logic [4:0]      o_rf_rs1,
    output logic [4:0]      o_rf_rs2,
    input  logic [XLEN-1:0] i_rf_data1,
    input  logic [XLEN-1:0] i_rf_data2,
    input  logic [4:0]      i_exmem_rd,
    input  logic [4:0]      i_memwb_rd,
    input  logic            i_exmem_reg_write,
    input  logic            i_memwb_reg_write,
    input  logic            i_exmem_mem_read,
    input  logic [XLEN-1:0] i_exmem_data,
    input  logic [XLEN-1:0] i_memwb_data,
    input  logic            i_flush,
    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [XLEN-1:0] o_ex_op1,
    output logic [XLEN-1:0] o_ex_op2,
    output logic [XLEN-1:0] o_ex_imm,
    output logic [4:0]      o_ex_rd,
    output logic            o_ex_reg_write,
    output logic            o_ex_mem_read,
    output logic [3:0]      o_ex_alu_op,
    output logic [15:0]     o_stall_cnt
);

    logic            r_s1_valid;
    logic [4:0]      r_s1_rs1;
    logic [4:0]      r_s1_rs2;
    logic [4:0]      r_s1_rd;
    logic            r_s1_reg_write;
    logic            r_s1_mem_read;
    logic [XLEN-1:0] r_s1_imm;
    logic [3:0]      r_s1_alu_op;

    logic            r_ex_valid;
    logic [XLEN-1:0] r_ex_op1;
    logic [XLEN-1:0] r_ex_op2;
    logic [XLEN-1:0] r_ex_imm;
    logic [4:0]      r_ex_rd;
    logic            r_ex_reg_write;
    logic            r_ex_mem_read;
    logic [3:0]      r_ex_alu_op;
    logic [15:0]     r_stall_cnt;

    logic            w_s2_adv;
    logic            w_hazard;
    logic            w_s1_adv;
    logic            w_accept;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    // A source register is blocked while its producer cannot yet supply it.
    function automatic logic src_hazard(input logic [4:0] src);
`ifdef OPERAND_FWD_EN
        return (src != 5'd0) &&
               ((r_ex_valid && r_ex_reg_write && (r_ex_rd == src)) ||
                (i_exmem_reg_write && i_exmem_mem_read && (i_exmem_rd == src)));
`else
        return (src != 5'd0) &&
               ((r_ex_valid && r_ex_reg_write && (r_ex_rd == src)) ||
                (i_exmem_reg_write && (i_exmem_rd == src)) ||
                (i_memwb_reg_write && (i_memwb_rd == src)));
`endif
    endfunction

    // Operand selection at the S1->S2 transfer; x0 always reads as zero.
    function automatic logic [XLEN-1:0] src_operand(input logic [4:0] src,
                                                   input logic [XLEN-1:0] rf);
        if (src == 5'd0)
            return '0;
`ifdef OPERAND_FWD_EN
        else if (i_exmem_reg_write && (i_exmem_rd == src))
            return i_exmem_data;
        else if (i_memwb_reg_write && (i_memwb_rd == src))
            return i_memwb_data;
`endif
        else
            return rf;
    endfunction

`ifndef OPERAND_FWD_EN
    logic w_unused_fwd;
    assign w_unused_fwd = ^{i_exmem_data, i_memwb_data, i_exmem_mem_read};
`endif

    assign w_s2_adv   = !r_ex_valid || i_ex_ready;
    assign w_hazard   = r_s1_valid && (src_hazard(r_s1_rs1) || src_hazard(r_s1_rs2));
    assign w_s1_adv   = r_s1_valid && !w_hazard && w_s2_adv;
    assign o_in_ready = !i_flush && (!r_s1_valid || w_s1_adv);
    assign w_accept   = i_in_valid && o_in_ready;

    // The bank is re-addressed every cycle so a stalled S1 sees fresh data.
    assign o_rf_rs1 = w_accept ? i_in_rs1 : r_s1_rs1;
    assign o_rf_rs2 = w_accept ? i_in_rs2 : r_s1_rs2;

    assign w_op1 = src_operand(r_s1_rs1, i_rf_data1);
    assign w_op2 = src_operand(r_s1_rs2, i_rf_data2);

    // S1: capture decoded instruction while its bank read is in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid     <= 1'b0;
            r_s1_rs1       <= '0;
            r_s1_rs2       <= '0;
            r_s1_rd        <= '0;
            r_s1_reg_write <= 1'b0;
            r_s1_mem_read  <= 1'b0;
            r_s1_imm       <= '0;
            r_s1_alu_op    <= '0;
        end else if (i_flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid     <= 1'b1;
            r_s1_rs1       <= i_in_rs1;
            r_s1_rs2       <= i_in_rs2;
            r_s1_rd        <= i_in_rd;
            r_s1_reg_write <= i_in_reg_write;
            r_s1_mem_read  <= i_in_mem_read;
            r_s1_imm       <= i_in_imm;
            r_s1_alu_op    <= i_in_alu_op;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2: registered execute outputs; load from S1 or take a bubble.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex_valid     <= 1'b0;
            r_ex_op1       <= '0;
            r_ex_op2       <= '0;
            r_ex_imm       <= '0;
            r_ex_rd        <= '0;
            r_ex_reg_write <= 1'b0;
            r_ex_mem_read  <= 1'b0;
            r_ex_alu_op    <= '0;
        end else if (i_flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_ex_valid <= w_s1_adv;
            if (w_s1_adv) begin
                r_ex_op1       <= w_op1;
                r_ex_op2       <= w_op2;
                r_ex_imm       <= r_s1_imm;
                r_ex_rd        <= r_s1_rd;
                r_ex_reg_write <= r_s1_reg_write;
                r_ex_mem_read  <= r_s1_mem_read;
                r_ex_alu_op    <= r_s1_alu_op;
            end
        end
    end

    // Saturating count of cycles S1 spends blocked on a hazard.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_stall_cnt <= '0;
        else if (w_hazard && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign o_ex_valid     = r_ex_valid;
    assign o_ex_op1       = r_ex_op1;
    assign o_ex_op2       = r_ex_op2;
    assign o_ex_imm       = r_ex_imm;
    assign o_ex_rd        = r_ex_rd;
    assign o_ex_reg_write = r_ex_reg_write;
    assign o_ex_mem_read  = r_ex_mem_read;
    assign o_ex_alu_op    = r_ex_alu_op;
    assign o_stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed stimulus, expected results queued
// at accept time and compared by an independent monitor at the handshake.
module tb_operand_fetch;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic [3:0]  alu;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_reg_write, in_mem_read;
    logic [31:0] in_imm;
    logic [3:0]  in_alu_op;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_data1, rf_data2;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write, exmem_mem_read;
    logic [31:0] exmem_data, memwb_data;
    logic        flush;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_op1, ex_op2, ex_imm;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read;
    logic [3:0]  ex_alu_op;
    logic [15:0] stall_cnt;

    int   checks = 0;
    int   errors = 0;
    int   seq = 0;
    int   exp_stall = 0;
    exp_t sb[$];
    logic [31:0] bank [32];

    always #5 clk = ~clk;

    operand_fetch #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_rs1(in_rs1), .i_in_rs2(in_rs2), .i_in_rd(in_rd),
        .i_in_reg_write(in_reg_write), .i_in_mem_read(in_mem_read),
        .i_in_imm(in_imm), .i_in_alu_op(in_alu_op),
        .o_rf_rs1(rf_rs1), .o_rf_rs2(rf_rs2),
        .i_rf_data1(rf_data1), .i_rf_data2(rf_data2),
        .i_exmem_rd(exmem_rd), .i_memwb_rd(memwb_rd),
        .i_exmem_reg_write(exmem_reg_write), .i_memwb_reg_write(memwb_reg_write),
        .i_exmem_mem_read(exmem_mem_read),
        .i_exmem_data(exmem_data), .i_memwb_data(memwb_data),
        .i_flush(flush),
        .o_ex_valid(ex_valid), .i_ex_ready(ex_ready),
        .o_ex_op1(ex_op1), .o_ex_op2(ex_op2), .o_ex_imm(ex_imm),
        .o_ex_rd(ex_rd), .o_ex_reg_write(ex_reg_write), .o_ex_mem_read(ex_mem_read),
        .o_ex_alu_op(ex_alu_op), .o_stall_cnt(stall_cnt)
    );

    // Register bank model: one-cycle read latency, MEM/WB writes are write-first.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) bank[i] <= 32'h1000 + i;
            bank[0]  <= 32'hDEAD_BEEF;
            bank[1]  <= 32'd9;
            bank[2]  <= 32'hF0A;
            rf_data1 <= '0;
            rf_data2 <= '0;
        end else begin
            if (memwb_reg_write && memwb_rd != 5'd0) bank[memwb_rd] <= memwb_data;
            rf_data1 <= (memwb_reg_write && memwb_rd == rf_rs1 && rf_rs1 != 5'd0) ? memwb_data : bank[rf_rs1];
            rf_data2 <= (memwb_reg_write && memwb_rd == rf_rs2 && rf_rs2 != 5'd0) ? memwb_data : bank[rf_rs2];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops and compares whenever a transfer to execute occurs.
    always @(negedge clk) begin
        exp_t e, a;
        #2;
        if (rst_n && ex_valid && ex_ready) begin
            a = '{ex_op1, ex_op2, ex_imm, ex_rd, ex_reg_write, ex_mem_read, ex_alu_op};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got op1=%h op2=%h rd=%0d with nothing expected",
                         ex_op1, ex_op2, ex_rd);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL ex_output: got op1=%h op2=%h imm=%h rd=%0d rw=%b mr=%b alu=%h expected op1=%h op2=%h imm=%h rd=%0d rw=%b mr=%b alu=%h",
                             a.op1, a.op2, a.imm, a.rd, a.rw, a.mr, a.alu,
                             e.op1, e.op2, e.imm, e.rd, e.rw, e.mr, e.alu);
                end
            end
        end
    end

    // Offer one instruction starting at a negedge; returns at the negedge after acceptance.
    task automatic accept(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic rw, input logic mr,
                          input logic [31:0] op1e, input logic [31:0] op2e);
        bit done = 0;
        seq++;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_reg_write = rw; in_mem_read = mr;
        in_imm = 32'h100 + seq; in_alu_op = 4'(seq);
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            #1;
            if (in_ready) begin
                sb.push_back('{op1e, op2e, 32'h100 + seq, rd, rw, mr, 4'(seq)});
                done = 1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected 1");
        end
    endtask

    task automatic set_exmem(input logic [4:0] rd, input logic rw, input logic mr, input logic [31:0] d);
        exmem_rd = rd; exmem_reg_write = rw; exmem_mem_read = mr; exmem_data = d;
    endtask

    task automatic set_memwb(input logic [4:0] rd, input logic rw, input logic [31:0] d);
        memwb_rd = rd; memwb_reg_write = rw; memwb_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_reg_write = 1'b0; in_mem_read = 1'b0; in_imm = '0; in_alu_op = '0;
        set_exmem(5'd0, 1'b0, 1'b0, 32'h0);
        set_memwb(5'd0, 1'b0, 32'h0);
        flush = 1'b0; ex_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_ex_op1", ex_op1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // No hazard: two-cycle latency, operands from the bank
        accept(5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 32'd9, 32'hF0A);
        #1 chk("lat_not_early", 32'(ex_valid), 32'd0);
        @(negedge clk);
        #1 chk("lat_valid_2cyc", 32'(ex_valid), 32'd1);
        repeat (3) @(negedge clk);

        // x0 never stalls or forwards, even with a pending load to x0
        set_exmem(5'd0, 1'b1, 1'b1, 32'h5555);
        accept(5'd0, 5'd1, 5'd0, 1'b0, 1'b0, 32'd0, 32'd9);
        @(negedge clk);
        #1 chk("x0_no_stall_valid", 32'(ex_valid), 32'd1);
        chk("x0_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        set_exmem(5'd0, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);

`ifdef OPERAND_FWD_EN
        // EX/MEM forward wins over MEM/WB
        accept(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 32'hABCD, 32'd0);
        set_exmem(5'd5, 1'b1, 1'b0, 32'hABCD);
        set_memwb(5'd5, 1'b1, 32'd1);
        @(negedge clk);
        set_exmem(5'd0, 1'b0, 1'b0, 32'h0);
        set_memwb(5'd0, 1'b0, 32'h0);
        // MEM/WB forward alone
        accept(5'd0, 5'd6, 5'd0, 1'b0, 1'b0, 32'd0, 32'h66);
        set_memwb(5'd6, 1'b1, 32'h66);
        @(negedge clk);
        set_memwb(5'd0, 1'b0, 32'h0);
        #1 chk("fwd_no_stall", 32'(stall_cnt), 32'(exp_stall));
        repeat (3) @(negedge clk);

        // Load-use: one bubble, then the loaded value forwarded from EX/MEM
        accept(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'd9, 32'hF0A);
        accept(5'd0, 5'd3, 5'd10, 1'b0, 1'b0, 32'd0, 32'h3333);
        @(negedge clk);
        set_exmem(5'd3, 1'b1, 1'b0, 32'h3333);
        exp_stall++;
        #1 chk("loaduse_bubble", 32'(ex_valid), 32'd0);
        chk("loaduse_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        @(negedge clk);
        set_exmem(5'd0, 1'b0, 1'b0, 32'h0);
        #1 chk("loaduse_resume", 32'(ex_valid), 32'd1);
        repeat (3) @(negedge clk);
`else
        // Pending MEM/WB write stalls until it retires, then bank value is used
        set_memwb(5'd4, 1'b1, 32'h44);
        accept(5'd4, 5'd0, 5'd11, 1'b0, 1'b0, 32'h44, 32'd0);
        repeat (3) @(negedge clk);
        exp_stall += 3;
        #1 chk("nofwd_stalled", 32'(ex_valid), 32'd0);
        chk("nofwd_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        set_memwb(5'd0, 1'b0, 32'h0);
        @(negedge clk);
        #1 chk("nofwd_resume", 32'(ex_valid), 32'd1);
        repeat (3) @(negedge clk);
`endif

        // Backpressure holds outputs; flush empties both stages
        ex_ready = 1'b0;
        accept(5'd1, 5'd2, 5'd8, 1'b0, 1'b0, 32'd9, 32'hF0A);
        accept(5'd2, 5'd1, 5'd9, 1'b0, 1'b0, 32'hF0A, 32'd9);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_valid", 32'(ex_valid), 32'd1);
            chk("bp_op1", ex_op1, 32'd9);
            chk("bp_op2", ex_op2, 32'hF0A);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        sb.delete();
        #1 chk("flush_ex_valid", 32'(ex_valid), 32'd0);
        chk("flush_blocks_ready", 32'(in_ready), 32'd0);
        flush = 1'b0;
        #1 chk("flush_s1_empty", 32'(in_ready), 32'd1);
        ex_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 chk("flush_no_leak", 32'(ex_valid), 32'd0);
        end
        chk("flush_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

        // Reset mid-stall discards S1 and S2
        @(negedge clk);
        ex_ready = 1'b0;
        accept(5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 32'd9, 32'hF0A);
        set_exmem(5'd4, 1'b1, 1'b1, 32'h0);
        accept(5'd4, 5'd0, 5'd12, 1'b0, 1'b0, 32'h0, 32'd0);
        repeat (2) @(negedge clk);
        exp_stall += 2;
        #1 chk("pre_rst_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        rst_n = 1'b0;
        #1;
        chk("midrst_ex_valid", 32'(ex_valid), 32'd0);
        chk("midrst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_ex_op1", ex_op1, 32'd0);
        sb.delete();
        exp_stall = 0;
        set_exmem(5'd0, 1'b0, 1'b0, 32'h0);
        ex_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1 chk("postrst_no_leak", 32'(ex_valid), 32'd0);
        end

        // Clean instruction after recovery
        accept(5'd2, 5'd1, 5'd13, 1'b1, 1'b0, 32'hF0A, 32'd9);
        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
